// File: rtl/uart_reg_loader.sv
// uart_reg_loader
// Turns a stream of received UART bytes into register-file writes during
// program/data load. Each frame is one header byte followed by four data
// bytes, most significant byte first. Each complete frame produces exactly one
// write cycle, using the UART_write_enable / distinct toggle handshake. A
// header with bit 7 set is the terminator. After it, the block ignores all
// input until reset.
//
// Parameters
//   TIMEOUT_CYCLES : idle cycles allowed while a frame is partly received
//                    (0 disables the timeout)
//   COUNT_W        : width of word_count
//
// Ports
//   CLK               : system clock, rising edge
//   reset             : asynchronous active-low reset
//   rx_data           : received byte, valid with rx_valid
//   rx_valid          : one-cycle strobe per received byte
//   UART_write_enable : one-cycle register-file write request
//   rw                : destination register index
//   write_data        : assembled 32-bit word
//   distinct          : write tag, toggles once per issued write
//   busy              : frame partially received or being written
//   load_done         : sticky, terminator seen
//   frame_error       : sticky, a frame was aborted by timeout
//   word_count        : words written since reset, wraps

module uart_reg_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned COUNT_W        = 8
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               UART_write_enable,
    output logic [4:0]         rw,
    output logic [31:0]        write_data,
    output logic               distinct,
    output logic               busy,
    output logic               load_done,
    output logic               frame_error,
    output logic [COUNT_W-1:0] word_count
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StData  = 2'd1;
    localparam logic [1:0] StWrite = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [31:0] TimeoutLimit = 32'(TIMEOUT_CYCLES);

    logic [1:0]         state_q, state_d;
    logic [4:0]         rw_q, rw_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [1:0]         idx_q, idx_d;
    logic [31:0]        tmo_q, tmo_d;
    logic               dist_q, dist_d;
    logic               done_q, done_d;
    logic               ferr_q, ferr_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        idx_d   = idx_q;
        tmo_d   = tmo_q;
        dist_d  = dist_q;
        done_d  = done_q;
        ferr_d  = ferr_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            // WRITE lasts one cycle and then behaves like IDLE. A header that
            // arrives in the write cycle is therefore accepted without loss.
            StIdle, StWrite: begin
                if (state_q == StWrite) begin
                    cnt_d = cnt_q + COUNT_W'(1);
                end
                state_d = StIdle;
                if (rx_valid) begin
                    if (rx_data[7]) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        rw_d    = rx_data[4:0];
                        idx_d   = 2'd0;
                        tmo_d   = 32'd0;
                        state_d = StData;
                    end
                end
            end

            StData: begin
                if (rx_valid) begin
                    wdata_d = {wdata_q[23:0], rx_data};
                    tmo_d   = 32'd0;
                    idx_d   = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        // Toggle the tag on the same edge that raises the
                        // write enable, so the two are presented together.
                        state_d = StWrite;
                        dist_d  = ~dist_q;
                    end
                end else begin
                    tmo_d = tmo_q + 32'd1;
                    // Abort the frame. rw/write_data keep what they hold,
                    // and no write is issued.
                    if ((TimeoutLimit != 32'd0) && (tmo_d == TimeoutLimit)) begin
                        state_d = StIdle;
                        ferr_d  = 1'b1;
                    end
                end
            end

            StDone: begin
                state_d = StDone;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            rw_q    <= 5'd0;
            wdata_q <= 32'd0;
            idx_q   <= 2'd0;
            tmo_q   <= 32'd0;
            // The register file's tag buffer resets to 1. Matching it means
            // no write is pending after reset.
            dist_q  <= 1'b1;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            dist_q  <= dist_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign UART_write_enable = (state_q == StWrite);
    assign busy              = (state_q == StData) || (state_q == StWrite);
    assign rw                = rw_q;
    assign write_data        = wdata_q;
    assign distinct          = dist_q;
    assign load_done         = done_q;
    assign frame_error       = ferr_q;
    assign word_count        = cnt_q;

endmodule

// File: tb/tb_uart_reg_loader.sv
module tb_uart_reg_loader;

    localparam int unsigned Timeout = 16;

    logic        CLK = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        UART_write_enable;
    logic [4:0]  rw;
    logic [31:0] write_data;
    logic        distinct;
    logic        busy;
    logic        load_done;
    logic        frame_error;
    logic [7:0]  word_count;

    int errors = 0;
    int checks = 0;

    uart_reg_loader #(
        .TIMEOUT_CYCLES(Timeout),
        .COUNT_W       (8)
    ) dut (
        .CLK              (CLK),
        .reset            (reset),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .UART_write_enable(UART_write_enable),
        .rw               (rw),
        .write_data       (write_data),
        .distinct         (distinct),
        .busy             (busy),
        .load_done        (load_done),
        .frame_error      (frame_error),
        .word_count       (word_count)
    );

    always #5 CLK = ~CLK;

    // Reference model: the bytes of the current frame are collected in a
    // queue. Five collected bytes make one write.
    logic [7:0]  frm[$];
    int          m_idle;
    logic        m_done, m_ferr, m_wr, m_dist;
    logic [7:0]  m_cnt;
    logic [4:0]  m_rw;
    logic [31:0] m_wd;

    task automatic model_reset();
        frm.delete();
        m_idle = 0;
        m_done = 1'b0;
        m_ferr = 1'b0;
        m_wr   = 1'b0;
        m_dist = 1'b1;
        m_cnt  = 8'd0;
        m_rw   = 5'd0;
        m_wd   = 32'd0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d);
        logic was_wr;
        was_wr = m_wr;
        m_wr   = 1'b0;
        if (was_wr) m_cnt = m_cnt + 8'd1;
        if (m_done) begin
            // terminator seen: everything ignored
        end else if (frm.size() == 0) begin
            if (v) begin
                if (d[7]) m_done = 1'b1;
                else begin
                    frm.push_back(d);
                    m_idle = 0;
                end
            end
        end else if (v) begin
            frm.push_back(d);
            m_idle = 0;
            if (frm.size() == 5) begin
                m_rw   = frm[0][4:0];
                m_wd   = {frm[1], frm[2], frm[3], frm[4]};
                m_wr   = 1'b1;
                m_dist = ~m_dist;
                frm.delete();
            end
        end else begin
            m_idle++;
            if (m_idle >= Timeout) begin
                frm.delete();
                m_ferr = 1'b1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("uwe", 32'(UART_write_enable), 32'(m_wr));
        chk("distinct", 32'(distinct), 32'(m_dist));
        chk("busy", 32'(busy), 32'((frm.size() != 0) || m_wr));
        chk("load_done", 32'(load_done), 32'(m_done));
        chk("frame_error", 32'(frame_error), 32'(m_ferr));
        chk("word_count", 32'(word_count), 32'(m_cnt));
        if (m_wr) begin
            chk("rw", 32'(rw), 32'(m_rw));
            chk("write_data", write_data, m_wd);
        end
    endtask

    task automatic tick(input logic v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        @(posedge CLK);
        model_step(v, d);
        #1;
        compare();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
    endtask

    task automatic send_frame(input logic [7:0] hdr, input logic [31:0] w, input int gap);
        tick(1'b1, hdr);
        for (int i = 3; i >= 0; i--) begin
            idle(gap);
            tick(1'b1, w[i*8 +: 8]);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_uwe", 32'(UART_write_enable), 32'd0);
        chk("rst_rw", 32'(rw), 32'd0);
        chk("rst_wd", write_data, 32'd0);
        chk("rst_distinct", 32'(distinct), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_frame_error", 32'(frame_error), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
    endtask

    // Entered at posedge+1 and left at posedge+1, so tick() stays aligned.
    task automatic do_reset();
        #3 reset = 1'b0;
        #1 chk_reset_vals();
        model_reset();
        @(posedge CLK);
        @(posedge CLK);
        #3 reset = 1'b1;
        @(posedge CLK);
        model_step(1'b0, 8'h00);
        #1 compare();
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        model_reset();
        @(posedge CLK);
        #1;
        do_reset();

        // Single frame
        send_frame(8'h05, 32'hDEADBEEF, 0);
        chk("f1_uwe", 32'(UART_write_enable), 32'd1);
        chk("f1_rw", 32'(rw), 32'd5);
        chk("f1_wd", write_data, 32'hDEADBEEF);
        chk("f1_distinct", 32'(distinct), 32'd0);
        idle(1);
        chk("f1_count", 32'(word_count), 32'd1);
        chk("f1_uwe_low", 32'(UART_write_enable), 32'd0);

        // Back-to-back frames: the second header lands in the write cycle
        do_reset();
        send_frame(8'h01, 32'h00000001, 0);
        chk("b2b_dist0", 32'(distinct), 32'd0);
        send_frame(8'h1F, 32'h12345678, 0);
        chk("b2b_rw", 32'(rw), 32'd31);
        chk("b2b_wd", write_data, 32'h12345678);
        chk("b2b_dist1", 32'(distinct), 32'd1);
        idle(1);
        chk("b2b_count", 32'(word_count), 32'd2);

        // Timeout after two data bytes
        do_reset();
        tick(1'b1, 8'h03);
        tick(1'b1, 8'hAA);
        tick(1'b1, 8'hBB);
        idle(15);
        chk("tmo_early", 32'(frame_error), 32'd0);
        idle(1);
        chk("tmo_ferr", 32'(frame_error), 32'd1);
        chk("tmo_busy", 32'(busy), 32'd0);
        send_frame(8'h04, 32'hCAFEF00D, 2);
        chk("tmo_next_wd", write_data, 32'hCAFEF00D);
        chk("tmo_next_rw", 32'(rw), 32'd4);
        idle(1);
        chk("tmo_count", 32'(word_count), 32'd1);

        // Header bits 6:5 are ignored
        send_frame(8'h67, 32'hA5A5A5A5, 1);
        chk("hdr67_rw", 32'(rw), 32'd7);
        idle(2);

        // Reset in the middle of a frame
        tick(1'b1, 8'h09);
        tick(1'b1, 8'h11);
        tick(1'b1, 8'h22);
        tick(1'b1, 8'h33);
        do_reset();
        send_frame(8'h0A, 32'h0BADF00D, 0);
        chk("post_rst_wd", write_data, 32'h0BADF00D);
        idle(1);

        // Random frames with varying gaps. Gaps of 17 force timeouts.
        for (int f = 0; f < 40; f++) begin
            logic [7:0] hdr;
            hdr = 8'($urandom_range(0, 127));
            tick(1'b1, hdr);
            for (int b = 0; b < 4; b++) begin
                int r;
                r = int'($urandom_range(0, 24));
                idle(r == 0 ? 17 : r % 4);
                tick(1'b1, 8'($urandom));
            end
            idle(int'($urandom_range(0, 2)));
        end
        idle(20);

        // Terminator, then everything is ignored
        begin
            logic [7:0] cnt_before;
            cnt_before = m_cnt;
            tick(1'b1, 8'h80);
            chk("term_done", 32'(load_done), 32'd1);
            send_frame(8'h02, 32'h11223344, 0);
            idle(3);
            chk("term_count", 32'(word_count), 32'(cnt_before));
            chk("term_busy", 32'(busy), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
